product_accumulator: RTL and testbench

//  Downstream consumer of the registered 16x16 multiplier. Sums a programmed

---
 rtl/product_accumulator.sv | 92 +++++++++
 tb/tb_product_accumulator.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// Sums a programmed number of unsigned products into a wide accumulator and hands the total over valid/ready.
// Optional feature: define SATURATE_EN to clamp the accumulator to all-ones on overflow (default build wraps).
module product_accumulator #(
  parameter int PROD_W = 33,
  parameter int ACC_W  = 48,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              in_valid,
  input  logic [PROD_W-1:0] p_in,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              busy,
  output logic              overflow
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W:0]   sum;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    // One extra bit so the carry out of the accumulator is visible.
    sum     = {1'b0, acc_q} + (ACC_W+1)'(p_in);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d = '0;
          ovf_d = 1'b0;
          rem_d = len;
          state_d = (len != '0) ? ST_ACCUM : ST_HOLD;
        end
      end
      ST_ACCUM: begin
        if (in_valid) begin
          ovf_d = ovf_q | sum[ACC_W];
`ifdef SATURATE_EN
          // Once clamped, stay clamped for the remainder of the run.
          acc_d = (sum[ACC_W] || ovf_q) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
          acc_d = sum[ACC_W-1:0];
`endif
          rem_d = rem_q - 1'b1;
          if (rem_q == CNT_W'(1)) begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_HOLD);
  assign busy      = (state_q == ST_ACCUM) || (state_q == ST_HOLD);
  assign acc_out   = acc_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed self-checking bench for product_accumulator; a second instance with ACC_W=34 exercises overflow.
module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic [32:0] p_in;
  logic        out_ready;

  logic        in_ready, out_valid, busy, overflow;
  logic [47:0] acc_out;
  logic        in_ready34, out_valid34, busy34, overflow34;
  logic [33:0] acc_out34;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  product_accumulator dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .p_in(p_in), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out),
    .busy(busy), .overflow(overflow)
  );

  product_accumulator #(.ACC_W(34)) dut34 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .p_in(p_in), .in_ready(in_ready34),
    .out_valid(out_valid34), .out_ready(out_ready), .acc_out(acc_out34),
    .busy(busy34), .overflow(overflow34)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %0d", tag, got);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
  endtask

  localparam logic [32:0] PMAX = 33'h1_FFFF_FFFF;

  initial begin
    logic [6:0] vpat;
    int         k;
    logic [63:0] exp34;

    rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0; p_in = '0; out_ready = 1'b0;
    cyc(); cyc();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_acc", acc_out, 0);
    check_eq("rst_ovf", overflow, 0);
    rst_n = 1'b1;
    cyc();

    // Test 1: 10+20+30
    start = 1'b1; len = 8'd3;
    cyc();
    start = 1'b0;
    check_eq("t1_in_ready", in_ready, 1);
    check_eq("t1_busy", busy, 1);
    in_valid = 1'b1; p_in = 33'd10; cyc();
    p_in = 33'd20; cyc();
    check_eq("t1_not_done", out_valid, 0);
    p_in = 33'd30; cyc();
    in_valid = 1'b0;
    check_eq("t1_out_valid", out_valid, 1);
    check_eq("t1_acc", acc_out, 60);
    check_eq("t1_ovf", overflow, 0);
    release_result();
    check_eq("t1_idle_busy", busy, 0);
    check_eq("t1_acc_kept", acc_out, 60);

    // Test 2: zero-length run
    start = 1'b1; len = 8'd0;
    cyc();
    start = 1'b0;
    check_eq("t2_out_valid", out_valid, 1);
    check_eq("t2_acc", acc_out, 0);
    release_result();
    check_eq("t2_busy", busy, 0);
    check_eq("t2_out_valid_low", out_valid, 0);

    // Test 3: gaps in in_valid are not counted
    vpat = 7'b1011001;  // bit i = in_valid on cycle i
    start = 1'b1; len = 8'd4;
    cyc();
    start = 1'b0;
    k = 1;
    for (int i = 0; i < 7; i++) begin
      in_valid = vpat[i];
      p_in = vpat[i] ? 33'(k) : 33'd99;
      if (vpat[i]) k++;
      cyc();
      if (i == 5) check_eq("t3_not_done", out_valid, 0);
    end
    in_valid = 1'b0;
    check_eq("t3_out_valid", out_valid, 1);
    check_eq("t3_acc", acc_out, 10);

    release_result();

    // Test 4: overflow on the 34-bit instance
    start = 1'b1; len = 8'd3;
    cyc();
    start = 1'b0;
    in_valid = 1'b1; p_in = PMAX;
    cyc(); cyc(); cyc();
    in_valid = 1'b0;
`ifdef SATURATE_EN
    exp34 = 64'h3_FFFF_FFFF;
`else
    exp34 = 64'h1_FFFF_FFFD;
`endif
    check_eq("t4_34_out_valid", out_valid34, 1);
    check_eq("t4_34_ovf", overflow34, 1);
    check_eq("t4_34_acc", acc_out34, exp34);
    check_eq("t4_48_ovf", overflow, 0);
    check_eq("t4_48_acc", acc_out, 64'd25769803773);

    // Test 5: HOLD is stable against in_valid and start
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; p_in = 33'd5; start = 1'b1; len = 8'd2;
      cyc();
      check_eq($sformatf("t5_acc_%0d", i), acc_out34, exp34);
      check_eq($sformatf("t5_out_valid_%0d", i), out_valid34, 1);
    end
    in_valid = 1'b0; start = 1'b0;
    check_eq("t5_ovf_kept", overflow34, 1);
    release_result();
    check_eq("t5_idle", busy34, 0);
    cyc();
    check_eq("t5_no_queued_start", busy34, 0);

    // Test 6: reset mid-run
    start = 1'b1; len = 8'd4;
    cyc();
    start = 1'b0;
    in_valid = 1'b1; p_in = 33'd1;
    cyc(); cyc();
    in_valid = 1'b0;
    check_eq("t6_mid_acc", acc_out, 2);
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_busy", busy, 0);
    check_eq("t6_rst_in_ready", in_ready, 0);
    check_eq("t6_rst_acc", acc_out, 0);
    check_eq("t6_rst_out_valid", out_valid, 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    start = 1'b1; len = 8'd1;
    cyc();
    start = 1'b0;
    in_valid = 1'b1; p_in = 33'd7;
    cyc();
    in_valid = 1'b0;
    check_eq("t6_out_valid", out_valid, 1);
    check_eq("t6_acc", acc_out, 7);
    release_result();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
